// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter sharing the FIFO write port among NREQ producers
// Optional feature: define FIFO_ARB_THROTTLE_EN to hold off new grants while fifo_threshold is high.
module fifo_wr_arbiter #(
   parameter int NREQ      = 4,
   parameter int DW        = 8,
   parameter int BURST_MAX = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NREQ-1:0]         req_valid,
   input  logic [NREQ*DW-1:0]      req_data,
   input  logic [NREQ-1:0]         req_last,
   output logic [NREQ-1:0]         req_ready,
   input  logic                    fifo_full,
   input  logic                    fifo_threshold,
   output logic                    fifo_wr,
   output logic [DW-1:0]           fifo_din,
   output logic [$clog2(NREQ)-1:0] grant_id,
   output logic                    busy
);

   localparam int IW = $clog2(NREQ);
   localparam int BW = 4;
   // beats+1 == BURST_MAX is evaluated as beats == BURST_MAX-1 to avoid a carry
   localparam logic [BW-1:0] BEAT_FINAL = BW'(BURST_MAX - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [BW-1:0] beats;
   logic [BW-1:0] beats_nxt;
   logic [IW-1:0] last_id;
   logic [IW-1:0] last_id_nxt;
   logic [IW-1:0] grant_id_nxt;

   logic          arb_allow;
   logic          arb_hit;
   logic [IW-1:0] arb_id;
   logic [IW-1:0] cand;

   logic          g_valid;
   logic          g_last;
   logic          xfer;

`ifdef FIFO_ARB_THROTTLE_EN
   assign arb_allow = ~fifo_threshold;
`else
   logic unused_threshold;
   assign unused_threshold = fifo_threshold;
   assign arb_allow        = 1'b1;
`endif

   // Search starts just past the previous grantee so it ends up with the lowest priority
   always_comb begin
      arb_hit = 1'b0;
      arb_id  = '0;
      cand    = '0;
      for (int k = 1; k <= NREQ; k++) begin
         cand = IW'((int'(last_id) + k) % NREQ);
         if (!arb_hit && req_valid[cand]) begin
            arb_hit = 1'b1;
            arb_id  = cand;
         end
      end
   end

   always_comb begin
      g_valid  = 1'b0;
      g_last   = 1'b0;
      fifo_din = req_data[DW-1:0];
      for (int i = 0; i < NREQ; i++) begin
         if (grant_id == IW'(i)) begin
            g_valid  = req_valid[i];
            g_last   = req_last[i];
            fifo_din = req_data[i*DW +: DW];
         end
      end
   end

   assign xfer = (state == GRANT) & g_valid & ~fifo_full;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         beats    <= '0;
         grant_id <= '0;
         last_id  <= IW'(NREQ - 1);
      end else begin
         state    <= state_nxt;
         beats    <= beats_nxt;
         grant_id <= grant_id_nxt;
         last_id  <= last_id_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      beats_nxt    = beats;
      last_id_nxt  = last_id;
      grant_id_nxt = grant_id;
      case (state)
         IDLE: begin
            if (arb_hit && arb_allow) begin
               state_nxt    = GRANT;
               beats_nxt    = '0;
               grant_id_nxt = arb_id;
               last_id_nxt  = arb_id;
            end
         end
         GRANT: begin
            if (xfer) begin
               beats_nxt = beats + BW'(1);
            end
            // A full FIFO only stalls the burst; dropping valid abandons it
            if (!g_valid || (xfer && (g_last || beats == BEAT_FINAL))) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy      = (state == GRANT);
      fifo_wr   = xfer;
      req_ready = '0;
      if (xfer) begin
         req_ready = NREQ'(1) << grant_id;
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - self-checking bench for fifo_wr_arbiter driving a behavioural 16-deep FIFO
module tb_fifo_wr_arbiter;

   localparam int NREQ      = 4;
   localparam int DW        = 8;
   localparam int BURST_MAX = 4;
   localparam int DEPTH     = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                 rst_n;
   logic [NREQ-1:0]      req_valid;
   logic [NREQ*DW-1:0]   req_data;
   logic [NREQ-1:0]      req_last;
   logic [NREQ-1:0]      req_ready;
   logic                 fifo_full;
   logic                 fifo_threshold;
   logic                 fifo_wr;
   logic [DW-1:0]        fifo_din;
   logic [1:0]           grant_id;
   logic                 busy;

   fifo_wr_arbiter #(.NREQ(NREQ), .DW(DW), .BURST_MAX(BURST_MAX)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .req_valid      (req_valid),
      .req_data       (req_data),
      .req_last       (req_last),
      .req_ready      (req_ready),
      .fifo_full      (fifo_full),
      .fifo_threshold (fifo_threshold),
      .fifo_wr        (fifo_wr),
      .fifo_din       (fifo_din),
      .grant_id       (grant_id),
      .busy           (busy)
   );

   int checks   = 0;
   int failures = 0;

   // producer beat queues ({last, data}) as ring buffers, and the FIFO contents
   logic [DW:0]     pmem [NREQ][256];
   int              phead [NREQ];
   int              ptail [NREQ];
   logic [NREQ-1:0] mute;
   logic [DW-1:0]   fq [$];
   logic            rd_req;
   logic            overflow;

   logic            s_wr, s_busy, s_full;
   logic [NREQ-1:0] s_ready, s_valid, s_last;
   logic [DW-1:0]   s_din;
   logic [1:0]      s_gid;

   function automatic logic pending(input int i);
      return phead[i] != ptail[i];
   endfunction

   task automatic push_beat(input int i, input logic [DW-1:0] d, input logic l);
      pmem[i][ptail[i]] = {l, d};
      ptail[i] = (ptail[i] + 1) & 255;
   endtask

   task automatic drive();
      for (int i = 0; i < NREQ; i++) begin
         req_valid[i]         = pending(i) && !mute[i];
         req_last[i]          = pending(i) ? pmem[i][phead[i]][DW] : 1'b0;
         req_data[i*DW +: DW] = pending(i) ? pmem[i][phead[i]][DW-1:0] : '0;
      end
      fifo_full      = (fq.size() >= DEPTH);
      fifo_threshold = (fq.size() >= DEPTH / 2);
   endtask

   // One clock: sample outputs at negedge, then apply accepted beats, FIFO writes and reads
   task automatic step();
      @(negedge clk);
      s_wr    = fifo_wr;
      s_busy  = busy;
      s_din   = fifo_din;
      s_gid   = grant_id;
      s_ready = req_ready;
      s_valid = req_valid;
      s_last  = req_last;
      s_full  = fifo_full;
      @(posedge clk);
      #1;
      if (rd_req && fq.size() > 0) void'(fq.pop_front());
      if (s_wr) begin
         if (s_full) overflow = 1'b1;
         else fq.push_back(s_din);
      end
      for (int i = 0; i < NREQ; i++) begin
         if (s_ready[i] && pending(i)) phead[i] = (phead[i] + 1) & 255;
      end
      drive();
   endtask

   task automatic clear_all();
      for (int i = 0; i < NREQ; i++) begin
         phead[i] = 0;
         ptail[i] = 0;
      end
      mute     = '0;
      rd_req   = 1'b0;
      overflow = 1'b0;
      fq.delete();
      drive();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      clear_all();
      for (int i = 0; i < NREQ; i++) push_beat(i, DW'((i + 1) * 16 + 5), 1'b0);
      mute = '1;
      drive();
      rst_n = 1'b0;
      #3;
      checks++; if (fifo_wr !== 1'b0) begin failures++; $display("FAIL reset_wr got=%b exp=0", fifo_wr); end
      checks++; if (req_ready !== 4'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
      checks++; if (grant_id !== 2'd0) begin failures++; $display("FAIL reset_gid got=%0d exp=0", grant_id); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (fifo_din !== 8'h15) begin failures++; $display("FAIL reset_din got=%h exp=15", fifo_din); end
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      clear_all();
   endtask

   task automatic test_single_packet();
      logic [4:0]    eb;
      logic [DW-1:0] ed [5];
      eb = 5'b01110;
      ed = '{8'h00, 8'hA1, 8'hA2, 8'hA3, 8'h00};
      clear_all();
      do_reset();
      push_beat(0, 8'hA1, 1'b0);
      push_beat(0, 8'hA2, 1'b0);
      push_beat(0, 8'hA3, 1'b1);
      drive();
      for (int c = 0; c < 5; c++) begin
         step();
         checks++; if (s_busy !== eb[c]) begin failures++; $display("FAIL single_busy cyc=%0d got=%b exp=%b", c, s_busy, eb[c]); end
         checks++; if (s_wr !== eb[c]) begin failures++; $display("FAIL single_wr cyc=%0d got=%b exp=%b", c, s_wr, eb[c]); end
         if (eb[c]) begin
            checks++; if (s_din !== ed[c]) begin failures++; $display("FAIL single_din cyc=%0d got=%h exp=%h", c, s_din, ed[c]); end
            checks++; if (s_ready !== 4'b0001) begin failures++; $display("FAIL single_ready cyc=%0d got=%b exp=0001", c, s_ready); end
         end
      end
   endtask

   task automatic test_round_robin();
      int phase, g, j;
      clear_all();
      do_reset();
      for (int i = 0; i < NREQ; i++)
         for (int b = 0; b < 12; b++) push_beat(i, DW'(i * 16 + b), 1'b0);
      rd_req = 1'b1;
      drive();
      // each grant is one idle bubble followed by BURST_MAX writes: grants 0,1,2,3,0
      for (int c = 0; c < 5 * (BURST_MAX + 1); c++) begin
         step();
         phase = c % (BURST_MAX + 1);
         g     = (c / (BURST_MAX + 1)) % NREQ;
         j     = ((c / (BURST_MAX + 1)) / NREQ) * BURST_MAX + phase - 1;
         checks++; if (s_busy !== (phase != 0)) begin failures++; $display("FAIL rr_busy cyc=%0d got=%b exp=%b", c, s_busy, phase != 0); end
         checks++; if (s_wr !== (phase != 0)) begin failures++; $display("FAIL rr_wr cyc=%0d got=%b exp=%b", c, s_wr, phase != 0); end
         if (phase != 0) begin
            checks++; if (s_gid !== 2'(g)) begin failures++; $display("FAIL rr_gid cyc=%0d got=%0d exp=%0d", c, s_gid, g); end
            checks++; if (s_din !== DW'(g * 16 + j)) begin failures++; $display("FAIL rr_din cyc=%0d got=%h exp=%h", c, s_din, DW'(g * 16 + j)); end
            checks++; if (s_ready !== 4'(1 << g)) begin failures++; $display("FAIL rr_ready cyc=%0d got=%b exp=%b", c, s_ready, 4'(1 << g)); end
         end
      end
      rd_req = 1'b0;
   endtask

   task automatic test_full_stall();
      clear_all();
      do_reset();
      for (int k = 0; k < DEPTH - 1; k++) fq.push_back(8'hEE);
      for (int b = 0; b < 4; b++) push_beat(1, DW'(8'hB0 + b), b == 3);
      drive();
      step();
      checks++; if (s_busy !== 1'b0) begin failures++; $display("FAIL full_idle got=%b exp=0", s_busy); end
      step();
      checks++; if (s_wr !== 1'b1 || s_din !== 8'hB0) begin failures++; $display("FAIL full_first wr=%b din=%h exp wr=1 din=b0", s_wr, s_din); end
      checks++; if (s_gid !== 2'd1) begin failures++; $display("FAIL full_gid got=%0d exp=1", s_gid); end
      for (int c = 0; c < 4; c++) begin
         step();
         checks++; if (s_busy !== 1'b1 || s_wr !== 1'b0 || s_ready !== 4'b0) begin
            failures++; $display("FAIL full_stall cyc=%0d busy=%b wr=%b ready=%b exp busy=1 wr=0 ready=0000", c, s_busy, s_wr, s_ready); end
      end
      rd_req = 1'b1;
      step();
      checks++; if (s_wr !== 1'b0) begin failures++; $display("FAIL full_readcyc got=%b exp=0", s_wr); end
      for (int b = 1; b < 4; b++) begin
         step();
         checks++; if (s_wr !== 1'b1 || s_din !== DW'(8'hB0 + b)) begin
            failures++; $display("FAIL full_resume beat=%0d wr=%b din=%h exp wr=1 din=%h", b, s_wr, s_din, DW'(8'hB0 + b)); end
      end
      step();
      checks++; if (s_busy !== 1'b0) begin failures++; $display("FAIL full_end got=%b exp=0", s_busy); end
      checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL full_overflow got=%b exp=0", overflow); end
      checks++; if (fq.size() != 14) begin failures++; $display("FAIL full_count got=%0d exp=14", fq.size()); end
      for (int b = 0; b < 4; b++) begin
         checks++; if (fq[10 + b] !== DW'(8'hB0 + b)) begin failures++; $display("FAIL full_order idx=%0d got=%h exp=%h", b, fq[10 + b], DW'(8'hB0 + b)); end
      end
      rd_req = 1'b0;
   endtask

   task automatic test_abandon();
      clear_all();
      do_reset();
      for (int b = 0; b < 4; b++) push_beat(2, DW'(8'hC0 + b), b == 3);
      push_beat(3, 8'hD0, 1'b0);
      push_beat(3, 8'hD1, 1'b1);
      rd_req = 1'b1;
      drive();
      step();
      checks++; if (s_busy !== 1'b0) begin failures++; $display("FAIL ab_idle got=%b exp=0", s_busy); end
      step();
      checks++; if (s_gid !== 2'd2 || s_wr !== 1'b1 || s_din !== 8'hC0) begin
         failures++; $display("FAIL ab_first gid=%0d wr=%b din=%h exp gid=2 wr=1 din=c0", s_gid, s_wr, s_din); end
      mute[2] = 1'b1;
      drive();
      step();
      checks++; if (s_busy !== 1'b1 || s_wr !== 1'b0 || s_ready !== 4'b0) begin
         failures++; $display("FAIL ab_drop busy=%b wr=%b ready=%b exp busy=1 wr=0 ready=0000", s_busy, s_wr, s_ready); end
      step();
      checks++; if (s_busy !== 1'b0) begin failures++; $display("FAIL ab_release got=%b exp=0", s_busy); end
      step();
      checks++; if (s_gid !== 2'd3 || s_wr !== 1'b1 || s_din !== 8'hD0) begin
         failures++; $display("FAIL ab_next gid=%0d wr=%b din=%h exp gid=3 wr=1 din=d0", s_gid, s_wr, s_din); end
      step();
      checks++; if (s_wr !== 1'b1 || s_din !== 8'hD1) begin failures++; $display("FAIL ab_next2 wr=%b din=%h exp wr=1 din=d1", s_wr, s_din); end
      step();
      checks++; if (s_busy !== 1'b0) begin failures++; $display("FAIL ab_end got=%b exp=0", s_busy); end
      rd_req = 1'b0;
   endtask

   task automatic test_threshold();
      clear_all();
      do_reset();
      for (int k = 0; k < DEPTH / 2; k++) fq.push_back(8'h77);
      push_beat(0, 8'h5A, 1'b1);
      drive();
`ifdef FIFO_ARB_THROTTLE_EN
      for (int c = 0; c < 3; c++) begin
         step();
         checks++; if (s_busy !== 1'b0 || s_wr !== 1'b0) begin failures++; $display("FAIL thr_hold cyc=%0d busy=%b wr=%b exp 0 0", c, s_busy, s_wr); end
      end
      rd_req = 1'b1;
      step();
      checks++; if (s_busy !== 1'b0) begin failures++; $display("FAIL thr_readcyc got=%b exp=0", s_busy); end
      rd_req = 1'b0;
      step();
      checks++; if (s_busy !== 1'b0) begin failures++; $display("FAIL thr_arb got=%b exp=0", s_busy); end
`else
      step();
      checks++; if (s_busy !== 1'b0) begin failures++; $display("FAIL thr_arb got=%b exp=0", s_busy); end
`endif
      step();
      checks++; if (s_busy !== 1'b1 || s_wr !== 1'b1 || s_din !== 8'h5A) begin
         failures++; $display("FAIL thr_grant busy=%b wr=%b din=%h exp busy=1 wr=1 din=5a", s_busy, s_wr, s_din); end
   endtask

   task automatic test_reset_mid_burst();
      clear_all();
      do_reset();
      for (int i = 0; i < NREQ; i++)
         for (int b = 0; b < 8; b++) push_beat(i, DW'(i * 16 + b + 1), 1'b0);
      mute = 4'b0011;
      drive();
      step();
      step();
      step();
      checks++; if (s_gid !== 2'd2 || s_wr !== 1'b1) begin failures++; $display("FAIL mid_pre gid=%0d wr=%b exp gid=2 wr=1", s_gid, s_wr); end
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (fifo_wr !== 1'b0 || req_ready !== 4'b0 || busy !== 1'b0) begin
         failures++; $display("FAIL mid_async wr=%b ready=%b busy=%b exp 0 0000 0", fifo_wr, req_ready, busy); end
      checks++; if (grant_id !== 2'd0 || fifo_din !== 8'h01) begin
         failures++; $display("FAIL mid_gid gid=%0d din=%h exp gid=0 din=01", grant_id, fifo_din); end
      checks++; if (fq.size() != 2) begin failures++; $display("FAIL mid_kept got=%0d exp=2", fq.size()); end
      mute = '0;
      drive();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step();
      checks++; if (s_busy !== 1'b0) begin failures++; $display("FAIL mid_idle got=%b exp=0", s_busy); end
      step();
      checks++; if (s_gid !== 2'd0 || s_wr !== 1'b1 || s_din !== 8'h01) begin
         failures++; $display("FAIL mid_win gid=%0d wr=%b din=%h exp gid=0 wr=1 din=01", s_gid, s_wr, s_din); end
   endtask

   // Reference: one grant at a time, round-robin after the last grantee, burst ends on last,
   // on BURST_MAX beats or when valid drops; writes only while not full
   task automatic test_random();
      int            m_busy, m_g, m_ptr, m_beats, len, pick, cidx, idx;
      logic          exp_wr;
      logic [DW-1:0] exp_din;
      clear_all();
      do_reset();
      m_busy  = 0;
      m_g     = 0;
      m_ptr   = NREQ - 1;
      m_beats = 0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!pending(i) && $urandom_range(0, 3) == 0) begin
               len = $urandom_range(1, 7);
               for (int b = 0; b < len; b++) push_beat(i, DW'($urandom), b == len - 1);
            end
         end
         if ($urandom_range(0, 7) == 0) begin
            idx = $urandom_range(0, NREQ - 1);
            mute[idx] = ~mute[idx];
         end
         rd_req = ($urandom_range(0, 2) == 0);
         drive();
         exp_din = pmem[m_g][phead[m_g]][DW-1:0];
         step();
         exp_wr = (m_busy != 0) && s_valid[m_g] && !s_full;
         checks++; if (s_busy !== (m_busy != 0)) begin failures++; $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", cyc, s_busy, m_busy != 0); end
         checks++; if (s_wr !== exp_wr) begin failures++; $display("FAIL rnd_wr cyc=%0d got=%b exp=%b", cyc, s_wr, exp_wr); end
         checks++; if (s_ready !== (exp_wr ? 4'(1 << m_g) : 4'b0)) begin
            failures++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, s_ready, exp_wr ? 4'(1 << m_g) : 4'b0); end
         if (m_busy != 0) begin
            checks++; if (s_gid !== 2'(m_g)) begin failures++; $display("FAIL rnd_gid cyc=%0d got=%0d exp=%0d", cyc, s_gid, m_g); end
         end
         if (exp_wr) begin
            checks++; if (s_din !== exp_din) begin failures++; $display("FAIL rnd_din cyc=%0d got=%h exp=%h", cyc, s_din, exp_din); end
         end
         if (m_busy == 0) begin
            pick = -1;
            for (int k = 1; k <= NREQ; k++) begin
               cidx = (m_ptr + k) % NREQ;
               if (pick < 0 && s_valid[cidx]) pick = cidx;
            end
            if (pick >= 0) begin
               m_g     = pick;
               m_ptr   = pick;
               m_busy  = 1;
               m_beats = 0;
            end
         end else if (exp_wr) begin
            m_beats++;
            if (s_last[m_g] || m_beats == BURST_MAX) m_busy = 0;
         end else if (!s_valid[m_g]) begin
            m_busy = 0;
         end
      end
      checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL rnd_overflow got=%b exp=0", overflow); end
      rd_req = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      clear_all();
      test_reset();
      test_single_packet();
      test_round_robin();
      test_full_stall();
      test_abandon();
      test_threshold();
      test_reset_mid_burst();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
      $fatal(1);
   end

endmodule
